vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Sequencing controller behind the coin-acceptor FSM. It takes one completed sale (vend flag plus change owed, in nickel units) over a valid/ready handshake. It then drives the product motor and the quarter/dime/nickel change hoppers one at a time, each under an acknowledge handshake with timeout. Only one actuator is ever energised at a time; the shared hopper power rail depends on this.

## Interface
- TIMEOUT_CYCLES, 16: cycles an actuator may stay energised without its done input before FAULT; legal range 2..255.
- clock  in  1  rising-edge clock.
- reset  in  1  reset reset, synchronous, active-high.
- req_valid  in  1  sale request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_vend  in  1  dispense one product; sampled with the request.
- req_change  in  3  change owed in nickel units (0..7 = 0..35 cents); sampled with the request.
- motor_on  out  1  product motor drive.
- motor_done  in  1  motor cycle complete.
- hop_q  out  1  quarter hopper drive (one coin).
- hop_d  out  1  dime hopper drive (one coin).
- hop_n  out  1  nickel hopper drive (one coin).
- hop_done  in  1  active hopper released one coin.
- done  out  1  one-cycle pulse: sale fully serviced.
- fault  out  1  actuator timeout; latched.
- fault_clr  in  1  clears FAULT.
- ctl_state  out  3  debug state code.

## Operation
- States and codes: IDLE=0, MOTOR=1, PICK=2, HOPPER=3, DONE=4, FAULT=5.
- IDLE: req_ready=1. On req_valid at an edge, latch rem<=req_change.
  - req_vend=1: go to MOTOR.
  - req_vend=0: go to PICK.
- MOTOR: motor_on=1. motor_done at an edge: go to PICK.
- PICK: one cycle, all drives low. Greedy selection on rem:
  - rem>=5: hop_q, rem-=5.
  - else rem>=2: hop_d, rem-=2.
  - else rem==1: hop_n, rem-=1.
  - rem==0: go to DONE.
  - Otherwise go to HOPPER with exactly the selected drive high.
- HOPPER: the selected drive stays high. hop_done at an edge: go to PICK.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: all drives low, fault=1, req_ready=0. fault_clr at an edge: go to IDLE, fault=0, rem=0.
- Timeout counter (8 bit):
  - Cleared on entry to MOTOR and HOPPER; increments each cycle spent there.
  - At count == TIMEOUT_CYCLES-1 with no done input: next state is FAULT.
  - A done input on that same edge wins; no fault.
- motor_done outside MOTOR and hop_done outside HOPPER are ignored.
- req_valid outside IDLE is ignored; there is no queueing.
- Coin sequences per rem value:
  - 7: Q, D.
  - 6: Q, N.
  - 5: Q.
  - 4: D, D.
  - 3: D, N.
  - 2: D.
  - 1: N.
- At most one of motor_on/hop_q/hop_d/hop_n is high in any cycle.

## Timing
- All outputs are registered and change only on the rising clock edge.
- Reset (any state, including mid-actuation) takes effect at the first edge with reset=1:
  - state=IDLE; req_ready=1.
  - motor_on, hop_q, hop_d, hop_n, done and fault all 0.
  - rem=0; timeout counter=0.
- Accept at edge k. The drive (motor_on, or the first PICK) is valid after edge k.
- Done input at edge m: the drive is low after edge m. The next drive is high after edge m+1, because PICK inserts one dead cycle between actuators.
- Final hop_done at edge p: PICK after p, done=1 after p+1, IDLE with req_ready=1 after p+2.
- Request with req_vend=0, req_change=0: PICK after edge k, done after k+1, IDLE after k+2.
- With immediate acks, a vend plus rem=7 sale is minimal: 1 (MOTOR) + 1 (PICK) + 1 (HOPPER Q) + 1 (PICK) + 1 (HOPPER D) + 1 (PICK) + 1 (DONE) = 7 cycles from accept to IDLE.

## Test plan
- Reset value check: reset high for 2 cycles mid-HOPPER with hop_d=1 -> after the first reset edge, all drives, done and fault are 0, req_ready=1 and ctl_state=0.
- Sale with req_vend=1, req_change=7, acks after 3 cycles each -> motor_on, then hop_q, then hop_d, each held until its ack, never overlapping; one done pulse; req_ready returns.
- Change only, req_vend=0, req_change=4 -> motor_on never asserted; exactly two hop_d pulses separated by one low cycle; done once.
- Request with req_vend=0, req_change=0 -> done two cycles after accept; no drives.
- Timeout: req_vend=1, motor_done held low -> motor_on high for exactly TIMEOUT_CYCLES=16 cycles, then fault=1 and all drives low. A new req_valid is ignored; fault_clr returns to IDLE with fault=0.
- Stray acks: hop_done pulses in MOTOR and motor_done pulses in HOPPER, plus req_valid pulses while busy -> no state change, no extra coins, no second sale accepted.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Sequences one sale: product motor, then greedy quarter/dime/nickel change, one actuator at a time.
// Drive is up one cycle after accept; req_ready is high only in IDLE and each actuator waits on its own done or times out.
module vend_dispense_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_vend,
    input  logic [2:0] req_change,
    output logic       motor_on,
    input  logic       motor_done,
    output logic       hop_q,
    output logic       hop_d,
    output logic       hop_n,
    input  logic       hop_done,
    output logic       done,
    output logic       fault,
    input  logic       fault_clr,
    output logic [2:0] ctl_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOTOR  = 3'd1,
        S_PICK   = 3'd2,
        S_HOPPER = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_Q    = 2'd1,
        COIN_D    = 2'd2,
        COIN_N    = 2'd3
    } coin_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    coin_t      coin_q, coin_d;
    logic [2:0] rem_q, rem_d;
    logic [7:0] tmo_q, tmo_d;

    logic req_ready_q, motor_on_q, hop_q_q, hop_d_q, hop_n_q, done_q, fault_q;

    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rem_d   = req_change;
                    tmo_d   = 8'd0;
                    state_d = req_vend ? S_MOTOR : S_PICK;
                end
            end
            S_MOTOR: begin
                // A done arriving on the last allowed edge beats the timeout.
                if (motor_done)            state_d = S_PICK;
                else if (tmo_q == TMO_LAST) state_d = S_FAULT;
                else                       tmo_d   = tmo_q + 8'd1;
            end
            S_PICK: begin
                tmo_d = 8'd0;
                if (rem_q >= 3'd5) begin
                    coin_d  = COIN_Q;
                    rem_d   = rem_q - 3'd5;
                    state_d = S_HOPPER;
                end else if (rem_q >= 3'd2) begin
                    coin_d  = COIN_D;
                    rem_d   = rem_q - 3'd2;
                    state_d = S_HOPPER;
                end else if (rem_q == 3'd1) begin
                    coin_d  = COIN_N;
                    rem_d   = 3'd0;
                    state_d = S_HOPPER;
                end else begin
                    coin_d  = COIN_NONE;
                    state_d = S_DONE;
                end
            end
            S_HOPPER: begin
                if (hop_done)              state_d = S_PICK;
                else if (tmo_q == TMO_LAST) state_d = S_FAULT;
                else                       tmo_d   = tmo_q + 8'd1;
            end
            S_DONE: state_d = S_IDLE;
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                    rem_d   = 3'd0;
                    tmo_d   = 8'd0;
                    coin_d  = COIN_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            coin_q      <= COIN_NONE;
            rem_q       <= 3'd0;
            tmo_q       <= 8'd0;
            req_ready_q <= 1'b1;
            motor_on_q  <= 1'b0;
            hop_q_q     <= 1'b0;
            hop_d_q     <= 1'b0;
            hop_n_q     <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            coin_q      <= coin_d;
            rem_q       <= rem_d;
            tmo_q       <= tmo_d;
            req_ready_q <= (state_d == S_IDLE);
            motor_on_q  <= (state_d == S_MOTOR);
            hop_q_q     <= (state_d == S_HOPPER) && (coin_d == COIN_Q);
            hop_d_q     <= (state_d == S_HOPPER) && (coin_d == COIN_D);
            hop_n_q     <= (state_d == S_HOPPER) && (coin_d == COIN_N);
            done_q      <= (state_d == S_DONE);
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign req_ready = req_ready_q;
    assign motor_on  = motor_on_q;
    assign hop_q     = hop_q_q;
    assign hop_d     = hop_d_q;
    assign hop_n     = hop_n_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign ctl_state = state_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed cycle-by-cycle vectors for vend_dispense_ctrl, plus timeout, same-edge ack and reset sequences.
module tb_vend_dispense_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid, req_vend, motor_done, hop_done, fault_clr;
    logic [2:0] req_change;
    logic       req_ready, motor_on, hop_q, hop_d, hop_n, done, fault;
    logic [2:0] ctl_state;

    vend_dispense_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vend   (req_vend),
        .req_change (req_change),
        .motor_on   (motor_on),
        .motor_done (motor_done),
        .hop_q      (hop_q),
        .hop_d      (hop_d),
        .hop_n      (hop_n),
        .hop_done   (hop_done),
        .done       (done),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .ctl_state  (ctl_state)
    );

    always #5 clock = ~clock;

    // Expected output word: {req_ready, motor_on, hop_q, hop_d, hop_n, done, fault, ctl_state}
    localparam logic [9:0] E_IDLE  = {1'b1, 4'b0000, 2'b00, 3'd0};
    localparam logic [9:0] E_MOTOR = {1'b0, 4'b1000, 2'b00, 3'd1};
    localparam logic [9:0] E_PICK  = {1'b0, 4'b0000, 2'b00, 3'd2};
    localparam logic [9:0] E_HQ    = {1'b0, 4'b0100, 2'b00, 3'd3};
    localparam logic [9:0] E_HD    = {1'b0, 4'b0010, 2'b00, 3'd3};
    localparam logic [9:0] E_HN    = {1'b0, 4'b0001, 2'b00, 3'd3};
    localparam logic [9:0] E_DONE  = {1'b0, 4'b0000, 2'b10, 3'd4};
    localparam logic [9:0] E_FAULT = {1'b0, 4'b0000, 2'b01, 3'd5};

    typedef struct {
        logic       rst;
        logic       rv;
        logic       vend;
        logic [2:0] chg;
        logic       md;
        logic       hd;
        logic       fc;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   tests  = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic rv, input logic vend,
                                input logic [2:0] chg, input logic md, input logic hd,
                                input logic fc, input logic [9:0] exp);
        vec_t v;
        v.rst = rst; v.rv = rv; v.vend = vend; v.chg = chg;
        v.md = md; v.hd = hd; v.fc = fc; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t nop(input logic [9:0] exp);
        return mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp);
    endfunction

    function automatic vec_t req(input logic vend, input logic [2:0] chg, input logic [9:0] exp);
        return mk(1'b0, 1'b1, vend, chg, 1'b0, 1'b0, 1'b0, exp);
    endfunction

    function automatic vec_t hack(input logic [9:0] exp);
        return mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, exp);
    endfunction

    function automatic vec_t mack(input logic [9:0] exp);
        return mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, exp);
    endfunction

    // Inputs are applied 1 ns after an edge, outputs sampled 1 ns after the next edge.
    task automatic step(input vec_t v, input string name, input int idx);
        logic [9:0] act;
        reset      = v.rst;
        req_valid  = v.rv;
        req_vend   = v.vend;
        req_change = v.chg;
        motor_done = v.md;
        hop_done   = v.hd;
        fault_clr  = v.fc;
        @(posedge clock);
        #1;
        act = {req_ready, motor_on, hop_q, hop_d, hop_n, done, fault, ctl_state};
        tests++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s[%0d] got {rdy,m,q,d,n,done,flt,st}=%b required %b", name, idx, act, v.exp);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_vend = 1'b0; req_change = 3'd0;
        motor_done = 1'b0; hop_done = 1'b0; fault_clr = 1'b0;
        @(posedge clock); #1;

        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_IDLE));
        tbl.push_back(nop(E_IDLE));
        // change only, 4 nickels: two dimes with a dead PICK cycle between
        tbl.push_back(req(1'b0, 3'd4, E_PICK));
        tbl.push_back(nop(E_HD));
        tbl.push_back(hack(E_PICK));
        tbl.push_back(nop(E_HD));
        tbl.push_back(hack(E_PICK));
        tbl.push_back(nop(E_DONE));
        tbl.push_back(nop(E_IDLE));
        // vend + 7, acks on the third cycle, stray acks and requests while busy
        tbl.push_back(req(1'b1, 3'd7, E_MOTOR));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_MOTOR));
        tbl.push_back(nop(E_MOTOR));
        tbl.push_back(mack(E_PICK));
        tbl.push_back(mack(E_HQ));
        tbl.push_back(mack(E_HQ));
        tbl.push_back(req(1'b1, 3'd1, E_HQ));
        tbl.push_back(hack(E_PICK));
        tbl.push_back(nop(E_HD));
        tbl.push_back(mack(E_HD));
        tbl.push_back(nop(E_HD));
        tbl.push_back(hack(E_PICK));
        tbl.push_back(nop(E_DONE));
        tbl.push_back(nop(E_IDLE));
        // zero sale: done two cycles after accept
        tbl.push_back(req(1'b0, 3'd0, E_PICK));
        tbl.push_back(nop(E_DONE));
        tbl.push_back(nop(E_IDLE));
        // 6 nickels: quarter then nickel
        tbl.push_back(req(1'b0, 3'd6, E_PICK));
        tbl.push_back(nop(E_HQ));
        tbl.push_back(hack(E_PICK));
        tbl.push_back(nop(E_HN));
        tbl.push_back(hack(E_PICK));
        tbl.push_back(nop(E_DONE));
        tbl.push_back(nop(E_IDLE));
        // 3 nickels with vend and immediate acks: motor, dime, nickel
        tbl.push_back(req(1'b1, 3'd3, E_MOTOR));
        tbl.push_back(mack(E_PICK));
        tbl.push_back(nop(E_HD));
        tbl.push_back(hack(E_PICK));
        tbl.push_back(nop(E_HN));
        tbl.push_back(hack(E_PICK));
        tbl.push_back(nop(E_DONE));
        tbl.push_back(nop(E_IDLE));

        foreach (tbl[i]) step(tbl[i], "vec", i);

        // motor timeout: 16 cycles energised, then latched fault
        step(req(1'b1, 3'd2, E_MOTOR), "tmo_accept", 0);
        for (int i = 0; i < 15; i++) step(nop(E_MOTOR), "tmo_motor", i);
        step(nop(E_FAULT), "tmo_fault", 0);
        step(req(1'b1, 3'd5, E_FAULT), "tmo_req_ignored", 0);
        step(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, E_FAULT), "tmo_acks_ignored", 0);
        step(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, E_IDLE), "tmo_clear", 0);
        step(req(1'b0, 3'd0, E_PICK), "post_clr_pick", 0);
        step(nop(E_DONE), "post_clr_done", 0);
        step(nop(E_IDLE), "post_clr_idle", 0);

        // hop_done on the last allowed edge wins over the timeout
        step(req(1'b0, 3'd5, E_PICK), "edge_accept", 0);
        step(nop(E_HQ), "edge_hq", 0);
        for (int i = 0; i < 15; i++) step(nop(E_HQ), "edge_hold", i);
        step(hack(E_PICK), "edge_ack_wins", 0);
        step(nop(E_DONE), "edge_done", 0);
        step(nop(E_IDLE), "edge_idle", 0);

        // reset mid-HOPPER with hop_d high
        step(req(1'b0, 3'd2, E_PICK), "rst_accept", 0);
        step(nop(E_HD), "rst_hd", 0);
        step(nop(E_HD), "rst_hd", 1);
        step(mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_IDLE), "rst_first_edge", 0);
        step(mk(1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, E_IDLE), "rst_second_edge", 0);
        step(nop(E_IDLE), "rst_release", 0);
        step(req(1'b0, 3'd1, E_PICK), "rst_after_pick", 0);
        step(nop(E_HN), "rst_after_hn", 0);
        step(hack(E_PICK), "rst_after_ack", 0);
        step(nop(E_DONE), "rst_after_done", 0);
        step(nop(E_IDLE), "rst_after_idle", 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
